// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product over WIDTH cycles.
// Signed operands are multiplied as magnitudes and the sign is applied at completion.
module seq_multiplier #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   p
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state_q, state_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0]   p_q, p_d;
   logic [WIDTH-1:0]     mplr_q, mplr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 sm_q, sm_d;
   logic                 sign_q, sign_d;
   logic                 accept;
   logic [2*WIDTH-1:0]   sum;

   // Magnitude of the most negative value wraps to 2^(WIDTH-1), which is correct unsigned.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
      return (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] v, input logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

   assign accept = start && (state_q != RUN);
   assign sum    = acc_q + (mplr_q[0] ? mcand_q : '0);

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      mplr_d  = mplr_q;
      cnt_d   = cnt_q;
      sm_d    = sm_q;
      sign_d  = sign_q;
      p_d     = p_q;
      busy    = (state_q == RUN);
      done    = (state_q == DONE);

      case (state_q)
         IDLE: if (accept) state_d = RUN;
         RUN: begin
            acc_d   = sum;
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            cnt_d   = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               p_d     = apply_sign(sum, sm_q && sign_q);
               state_d = DONE;
            end
         end
         DONE:    state_d = accept ? RUN : IDLE;
         default: state_d = IDLE;
      endcase

      if (accept) begin
         sm_d    = signed_mode;
         sign_d  = signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
         mcand_d = {{WIDTH{1'b0}}, magnitude(a, signed_mode)};
         mplr_d  = magnitude(b, signed_mode);
         acc_d   = '0;
         cnt_d   = CNT_W'(WIDTH);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         mcand_q <= '0;
         mplr_q  <= '0;
         cnt_q   <= '0;
         sm_q    <= 1'b0;
         sign_q  <= 1'b0;
         p_q     <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         mplr_q  <= mplr_d;
         cnt_q   <= cnt_d;
         sm_q    <= sm_d;
         sign_q  <= sign_d;
         p_q     <= p_d;
      end
   end

   assign p = p_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed scoreboard bench for seq_multiplier at WIDTH=4 and WIDTH=8.
module tb_seq_multiplier;

   typedef struct {
      logic [15:0] prod;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        s4 = 1'b0, sm4 = 1'b0, s8 = 1'b0, sm8 = 1'b0;
   logic [3:0]  a4 = '0, b4 = '0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        busy4, done4, busy8, done8;
   logic [7:0]  p4;
   logic [15:0] p8;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   bcnt4   = 0;
   int   bcnt8   = 0;
   exp_t q4[$];
   exp_t q8[$];

   seq_multiplier #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(s4), .signed_mode(sm4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .p(p4));

   seq_multiplier #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(s8), .signed_mode(sm8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .p(p8));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard side: pop and compare on every done pulse.
   always @(negedge clk) begin
      exp_t e;
      if (done4) begin
         chk("w4_busy_with_done", {31'd0, busy4}, 32'd0);
         chk("w4_done_expected", {31'd0, q4.size() != 0}, 32'd1);
         chk("w4_busy_len", bcnt4, 4);
         if (q4.size() != 0) begin
            e = q4.pop_front();
            chk("w4_prod", {24'd0, p4}, {16'd0, e.prod});
            chk("w4_latency", cyc, e.cyc);
         end
         bcnt4 = 0;
      end else if (busy4) bcnt4++;
      else bcnt4 = 0;

      if (done8) begin
         chk("w8_busy_with_done", {31'd0, busy8}, 32'd0);
         chk("w8_done_expected", {31'd0, q8.size() != 0}, 32'd1);
         chk("w8_busy_len", bcnt8, 8);
         if (q8.size() != 0) begin
            e = q8.pop_front();
            chk("w8_prod", {16'd0, p8}, {16'd0, e.prod});
            chk("w8_latency", cyc, e.cyc);
         end
         bcnt8 = 0;
      end else if (busy8) bcnt8++;
      else bcnt8 = 0;
   end

   task automatic wait_drain(input string tag);
      int n = 0;
      while ((q4.size() != 0 || q8.size() != 0) && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {31'd0, (q4.size() == 0 && q8.size() == 0)}, 32'd1);
   endtask

   task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic sm, input logic [7:0] exp);
      @(negedge clk);
      s4 = 1'b1; a4 = a; b4 = b; sm4 = sm;
      q4.push_back('{prod: {8'd0, exp}, cyc: cyc + 5});
      @(negedge clk);
      s4 = 1'b0;
      wait_drain("w4_drain");
   endtask

   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sm, input logic [15:0] exp);
      @(negedge clk);
      s8 = 1'b1; a8 = a; b8 = b; sm8 = sm;
      q8.push_back('{prod: exp, cyc: cyc + 9});
      @(negedge clk);
      s8 = 1'b0;
      wait_drain("w8_drain");
   endtask

   initial begin
      int n;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_busy4", {31'd0, busy4}, 32'd0);
      chk("rst_done4", {31'd0, done4}, 32'd0);
      chk("rst_p4", {24'd0, p4}, 32'd0);
      chk("rst_p8", {16'd0, p8}, 32'd0);

      run4(4'd15, 4'd15, 1'b0, 8'hE1);
      run4(4'h8, 4'h8, 1'b1, 8'h40);
      run4(4'hF, 4'd7, 1'b1, 8'hF9);
      run4(4'd0, 4'hB, 1'b1, 8'h00);

      // Back-to-back with start held; second operands appear in the first done cycle.
      @(negedge clk);
      s4 = 1'b1; a4 = 4'd3; b4 = 4'd5; sm4 = 1'b0;
      q4.push_back('{prod: 16'h000F, cyc: cyc + 5});
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done4 && n < 20);
      chk("b2b_first_done_seen", {31'd0, done4}, 32'd1);
      a4 = 4'd15; b4 = 4'd2;
      q4.push_back('{prod: 16'h001E, cyc: cyc + 5});
      @(negedge clk);
      s4 = 1'b0;
      chk("b2b_busy_after_done", {31'd0, busy4}, 32'd1);
      wait_drain("b2b_drain");

      // Start pulse mid-RUN must be ignored.
      @(negedge clk);
      s4 = 1'b1; a4 = 4'd6; b4 = 4'd7;
      q4.push_back('{prod: 16'h002A, cyc: cyc + 5});
      @(negedge clk);
      s4 = 1'b0;
      @(negedge clk);
      s4 = 1'b1; a4 = 4'd1; b4 = 4'd1;
      @(negedge clk);
      s4 = 1'b0;
      wait_drain("ign_drain");
      repeat (6) @(negedge clk);
      chk("ign_p_held", {24'd0, p4}, 32'h2A);

      // Reset during RUN aborts the operation.
      s4 = 1'b1; a4 = 4'd9; b4 = 4'd9;
      @(negedge clk);
      s4 = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", {31'd0, busy4}, 32'd0);
      chk("abort_done", {31'd0, done4}, 32'd0);
      chk("abort_p", {24'd0, p4}, 32'd0);
      repeat (8) @(negedge clk);
      run4(4'd2, 4'd3, 1'b0, 8'h06);

      run8(8'hFF, 8'hFF, 1'b0, 16'hFE01);
      run8(8'h80, 8'h7F, 1'b1, 16'hC080);
      repeat (4) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
